regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each register-file entry.
REQ-002 SHALL have parameter NREG, default 8, number of register-file entries; destination index width is $clog2(NREG) (3 at default).
REQ-003 SHALL have port clk input 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-low reset.
REQ-005 SHALL have port a_valid input 1: requester A (ALU writeback) has a write pending.
REQ-006 SHALL have port a_dest input $clog2(NREG): requester A destination register.
REQ-007 SHALL have port a_data input WIDTH: requester A write data.
REQ-008 SHALL have port a_ready output 1: requester A write accepted this cycle.
REQ-009 SHALL have ports b_valid, b_dest, b_data, b_ready with the same widths and meanings for requester B (memory-load writeback).
REQ-010 SHALL have port hold input 1: when 1, no write is accepted.
REQ-011 SHALL have port alloc_valid input 1: an issued instruction claims a destination register.
REQ-012 SHALL have port alloc_dest input $clog2(NREG): register being claimed.
REQ-013 SHALL have port wr_load output NREG: one-hot load enables driving the register-file entries.
REQ-014 SHALL have port wr_data output WIDTH: data driven to every register-file entry input.
REQ-015 SHALL have port busy output NREG: bit i = 1 while register i has an outstanding claimed write.

Function
REQ-016 SHALL accept at most one write per cycle.
REQ-017 SHALL, when hold=0, grant the only valid requester if exactly one of a_valid/b_valid is 1.
REQ-018 SHALL, when hold=0 and both valid, grant the requester selected by a 1-bit round-robin pointer (0 = A, 1 = B).
REQ-019 SHALL update the pointer only on a contended grant, to point at the non-granted requester; an uncontended grant leaves it unchanged.
REQ-020 SHALL drive a_ready/b_ready combinationally from the grant; a transfer occurs when valid and ready are both 1.
REQ-021 SHALL drive both ready outputs to 0 while hold=1; pointer and pending requests are unaffected.
REQ-022 SHALL require requesters to hold valid, dest and data stable until their transfer occurs; behaviour on violation is undefined.
REQ-023 SHALL register the accepted write: on the edge after a transfer, wr_load = one-hot(dest) and wr_data = accepted data, held for exactly one cycle (latency 1).
REQ-024 SHALL drive wr_load to all-zero on every cycle following a cycle without a transfer; wr_data then holds its last value.
REQ-025 SHALL set busy[alloc_dest] on the edge where alloc_valid=1.
REQ-026 SHALL clear busy[dest] on the edge where a transfer to dest occurs.
REQ-027 SHALL, when alloc and transfer target the same register on the same edge, leave that busy bit set (set wins).
REQ-028 SHALL process two requests to the same destination in grant order, so the later-granted data is the final register contents.
REQ-029 SHALL guarantee that under continuous contention neither requester waits more than one cycle between grants.
REQ-030 SHALL ignore a_dest/b_dest/alloc_dest values >= NREG: no load pulse and no busy update.

Reset
REQ-031 SHALL, while reset=0, force wr_load=0, wr_data=0, busy=0, pointer=A and both ready outputs to 0, asynchronously.
REQ-032 SHALL discard any write accepted in the cycle reset asserts; no load pulse is produced for it after release.
REQ-033 SHALL resume arbitration on the first rising clk edge after reset deasserts, with A favoured on the first contention.

Verification
REQ-034 SHALL cover single request: a_valid=1, a_dest=3, a_data=16'h1234 -> a_ready=1 same cycle; next cycle wr_load=8'h08 and wr_data=16'h1234.
REQ-035 SHALL cover contention: A(dest 1, 16'hAAAA) and B(dest 2, 16'hBBBB) valid for two cycles after reset -> A granted first, B second; wr_load sequence 8'h02 then 8'h04.
REQ-036 SHALL cover the scoreboard: alloc_valid=1, alloc_dest=5 -> busy=8'h20; a B write to dest 5 -> busy=8'h00 on the same edge as the transfer.
REQ-037 SHALL cover set-wins: busy[4]=1, alloc_dest=4 with a simultaneous transfer to dest 4 -> busy[4] remains 1.
REQ-038 SHALL cover hold: hold=1 with both requesters valid for 3 cycles -> both readies 0 and wr_load=0 throughout; on hold=0 the pointer-selected requester is granted.
REQ-039 SHALL cover reset mid-operation: assert reset between clock edges while busy=8'hFF and a transfer is in flight -> busy and wr_load go to 0 immediately, with no load pulse after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources (A = ALU, B = load unit) compete for the single write
// port. A 1-bit round-robin pointer breaks ties. The accepted write appears
// one cycle later as a one-hot load strobe plus shared data bus. A per-register
// busy scoreboard is set by allocation and cleared by writeback; set wins.

// Per-register slot: owns the busy bit and the load strobe for one entry.
module regfile_wb_slot #(
  parameter int DW  = 3,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          xfer,
  input  logic [DW-1:0] xfer_dest,
  input  logic          alloc_valid,
  input  logic [DW-1:0] alloc_dest,
  output logic          busy,
  output logic          load
);
  logic hit_wr, hit_alloc;

  // An index match can never fire for dest >= NREG because no slot owns it.
  assign hit_wr    = xfer && (xfer_dest == DW'(IDX));
  assign hit_alloc = alloc_valid && (alloc_dest == DW'(IDX));

  // Load strobe is the registered write hit; busy set has priority over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      load <= 1'b0;
    end else begin
      load <= hit_wr;
      busy <= hit_alloc | (busy & ~hit_wr);
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [$clog2(NREG)-1:0]  a_dest,
  input  logic [WIDTH-1:0]         a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [$clog2(NREG)-1:0]  b_dest,
  input  logic [WIDTH-1:0]         b_data,
  output logic                     b_ready,
  input  logic                     hold,
  input  logic                     alloc_valid,
  input  logic [$clog2(NREG)-1:0]  alloc_dest,
  output logic [NREG-1:0]          wr_load,
  output logic [WIDTH-1:0]         wr_data,
  output logic [NREG-1:0]          busy
);
  localparam int DW = $clog2(NREG);

  typedef struct packed {
    logic [DW-1:0]    dest;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t a_req, b_req, sel;
  logic    ptr;      // 0: A wins next contention, 1: B wins
  logic    contend;
  logic    gnt_a, gnt_b, xfer;

  assign a_req = '{dest: a_dest, data: a_data};
  assign b_req = '{dest: b_dest, data: b_data};

  // Grant: sole requester wins, pointer breaks ties; reset and hold block all.
  always_comb begin
    contend = a_valid & b_valid & ~hold;
    gnt_a   = reset & ~hold & a_valid & (~b_valid | ~ptr);
    gnt_b   = reset & ~hold & b_valid & (~a_valid |  ptr);
    xfer    = gnt_a | gnt_b;
    sel     = gnt_b ? b_req : a_req;
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // Pointer moves only on a contended grant, to the loser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ptr <= 1'b0;
    else if (contend) ptr <= gnt_a;
  end

  // Shared write data bus; holds the last accepted value between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    wr_data <= '0;
    else if (xfer) wr_data <= sel.data;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_slot
    regfile_wb_slot #(.DW(DW), .IDX(i)) u_slot (
      .clk         (clk),
      .reset       (reset),
      .xfer        (xfer),
      .xfer_dest   (sel.dest),
      .alloc_valid (alloc_valid),
      .alloc_dest  (alloc_dest),
      .busy        (busy[i]),
      .load        (wr_load[i])
    );
  end
endmodule
